// File: rtl/column_feeder_if.sv
// Column feeder bus: frame control and pixel input towards the feeder,
// the 3-pixel column, the column enable and the frame status back out.
interface column_feeder_if #(
    parameter int BIT_LENGTH = 5
);
    logic                  start;
    logic                  in_valid;
    logic [BIT_LENGTH-1:0] pixel_in;
    logic [BIT_LENGTH-1:0] pixel_out0;
    logic [BIT_LENGTH-1:0] pixel_out1;
    logic [BIT_LENGTH-1:0] pixel_out2;
    logic                  enable;
    logic                  done;
    logic                  gap_err;

    // The feeder itself: takes raster pixels in, drives columns out.
    modport master (
        input  start, in_valid, pixel_in,
        output pixel_out0, pixel_out1, pixel_out2, enable, done, gap_err
    );

    // The surrounding system: supplies pixels and observes the columns.
    modport slave (
        output start, in_valid, pixel_in,
        input  pixel_out0, pixel_out1, pixel_out2, enable, done, gap_err
    );
endinterface

// File: rtl/column_feeder.sv
// Column feeder: turns a raster-order pixel stream into vertically aligned
// 3-pixel columns (rows r-2, r-1, r) for a 3x3 median filter. Two line
// buffers of depth IMG_W hold the previous two rows; the first two rows only
// fill the buffers, every later pixel emits one column a cycle after it is
// accepted.
module column_feeder #(
    parameter int BIT_LENGTH = 5,
    parameter int IMG_W      = 16,
    parameter int IMG_H      = 16
) (
    input logic              clk,
    input logic              reset,
    column_feeder_if.master  bus
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_ONE  = RW'(1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    typedef enum logic [1:0] {IDLE, FILL, STREAM, DONE} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         col_q, col_d;
    logic [RW-1:0]         row_q, row_d;
    logic [BIT_LENGTH-1:0] lb0_q [IMG_W];
    logic [BIT_LENGTH-1:0] lb0_d [IMG_W];
    logic [BIT_LENGTH-1:0] lb1_q [IMG_W];
    logic [BIT_LENGTH-1:0] lb1_d [IMG_W];
    logic [BIT_LENGTH-1:0] out0_q, out0_d;
    logic [BIT_LENGTH-1:0] out1_q, out1_d;
    logic [BIT_LENGTH-1:0] out2_q, out2_d;
    logic                  enable_q, enable_d;
    logic                  done_q, done_d;
    logic                  gap_err_q, gap_err_d;
    logic                  accept;

    // Next-state logic: frame FSM, column emission, line buffer shift and raster counters.
    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        lb0_d     = lb0_q;
        lb1_d     = lb1_q;
        out0_d    = out0_q;
        out1_d    = out1_q;
        out2_d    = out2_q;
        enable_d  = 1'b0;
        done_d    = done_q;
        gap_err_d = gap_err_q;
        accept    = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d   = FILL;
                    col_d     = '0;
                    row_d     = '0;
                    done_d    = 1'b0;
                    gap_err_d = 1'b0;
                end
            end
            FILL: begin
                if (bus.in_valid) begin
                    accept = 1'b1;
                    if (row_q == ROW_ONE && col_q == COL_LAST) begin
                        state_d = STREAM;
                    end
                end
            end
            STREAM: begin
                if (bus.in_valid) begin
                    accept   = 1'b1;
                    out0_d   = lb1_q[IMG_W-1];
                    out1_d   = lb0_q[IMG_W-1];
                    out2_d   = bus.pixel_in;
                    enable_d = 1'b1;
                    if (row_q == ROW_LAST && col_q == COL_LAST) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end else begin
                    // A stalled source ends the frame; the filter sees enable drop.
                    gap_err_d = 1'b1;
                    state_d   = DONE;
                    done_d    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            for (int i = IMG_W - 1; i > 0; i--) begin
                lb0_d[i] = lb0_q[i-1];
                lb1_d[i] = lb1_q[i-1];
            end
            lb0_d[0] = bus.pixel_in;
            lb1_d[0] = lb0_q[IMG_W-1];
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    // State and output registers, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            col_q     <= '0;
            row_q     <= '0;
            for (int i = 0; i < IMG_W; i++) begin
                lb0_q[i] <= '0;
                lb1_q[i] <= '0;
            end
            out0_q    <= '0;
            out1_q    <= '0;
            out2_q    <= '0;
            enable_q  <= 1'b0;
            done_q    <= 1'b0;
            gap_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            lb0_q     <= lb0_d;
            lb1_q     <= lb1_d;
            out0_q    <= out0_d;
            out1_q    <= out1_d;
            out2_q    <= out2_d;
            enable_q  <= enable_d;
            done_q    <= done_d;
            gap_err_q <= gap_err_d;
        end
    end

    assign bus.pixel_out0 = out0_q;
    assign bus.pixel_out1 = out1_q;
    assign bus.pixel_out2 = out2_q;
    assign bus.enable     = enable_q;
    assign bus.done       = done_q;
    assign bus.gap_err    = gap_err_q;

endmodule
